updown_mod_counter: RTL
=======================

# updown_mod_counter

Parametrised up/down modulo counter. It is the next-generation replacement for the fixed-width load/ce/up_down counter in the counter subsystem. It adds a runtime modulo limit, a programmable step, wrap or saturate overflow handling, a terminal-count pulse and sticky status flags. It sits beside the existing counter interface and is checked by a companion assertion module.

## Interface

Parameters:
- WIDTH, 8, count width in bits; legal range 2..32.
- STEP_W, 4, step input width; must satisfy STEP_W <= WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- ce  input  1  count enable.
- load_n  input  1  active-low synchronous load.
- up_down  input  1  direction: 1 counts up, 0 counts down.
- data_load  input  WIDTH  load value.
- limit  input  WIDTH  modulo limit; the count range is 0..limit inclusive.
- step  input  STEP_W  increment/decrement amount, unsigned.
- sat_en  input  1  1 selects saturate mode, 0 selects wrap mode.
- clr_flags  input  1  synchronous clear of the sticky flags.
- count_out  output  WIDTH  registered count.
- zero  output  1  combinational, (count_out == 0).
- at_limit  output  1  combinational, (count_out == limit).
- tc  output  1  registered one-cycle terminal-count pulse.
- wrap_flag  output  1  sticky: a boundary crossing has occurred.
- load_err  output  1  sticky: a load value exceeded limit.

## Operation

- Priority per cycle: reset > load (load_n=0) > count (ce=1) > hold.
- Load:
  - count_out <= data_load when data_load <= limit.
  - Otherwise count_out <= limit and load_err is set.
  - Load ignores ce and step and generates no tc.
- Hold: ce=0, or step=0, leaves count_out unchanged and produces no event.
- Arithmetic uses WIDTH+1 bits internally; there is no silent modular truncation at 2^WIDTH.
- Up count, with s = step zero-extended to WIDTH+1:
  - If count+s <= limit: next = count+s.
  - Otherwise a boundary event occurs.
  - Wrap mode: next = count+s-(limit+1). If that result is still > limit (step larger than the range), next = 0.
  - Saturate mode: next = limit.
- Down count:
  - If s <= count: next = count-s.
  - Otherwise a boundary event occurs.
  - Wrap mode: next = limit-(s-count-1). If s-count-1 > limit, next = limit.
  - Saturate mode: next = 0.
- Boundary event:
  - tc=1 in the following cycle.
  - wrap_flag set; this applies in saturate mode as well.
  - A count that lands exactly on limit or 0 is not an event.
- Sticky flags: when clr_flags coincides with a set condition, set wins. Otherwise clr_flags clears both wrap_flag and load_err.
- limit changes mid-count:
  - Take effect on the next count or load operation.
  - If count_out > new limit while holding, count_out is not altered; at_limit=0.
  - The next up step in that state is a boundary event.
  - The next down step is evaluated normally against count.
- limit=0: count pins at 0. Any up or down step with step>0 is a boundary event; wrap and saturate both give 0.

## Timing

- Reset values (async assertion, immediate): count_out=0, tc=0, wrap_flag=0, load_err=0. zero=1 and at_limit follows limit.
- Reset deassertion is synchronised externally; the first counting edge is the first rising clk with rst_n=1.
- Load and count latency are both 1 cycle: input sampled at edge N, count_out valid after edge N.
- tc:
  - Asserted for exactly one cycle, registered at the same edge as the count update that caused the event.
  - Back-to-back events give back-to-back tc cycles.
- zero and at_limit are purely combinational from count_out and limit; no extra latency.
- Reset asserted mid-operation aborts everything, including a pending tc. No flag survives reset.

## Test plan

- Reset/load: rst_n low mid-count at count 5 -> count_out=0 and flags 0 immediately. Then load_n=0 with data_load=9, limit=12 -> count_out=9 next cycle, tc=0.
- Wrap up: limit=9, step=3, up, wrap, count=8 -> next=1; tc=1 for one cycle; wrap_flag=1. Then clr_flags -> wrap_flag=0.
- Wrap down and step larger than range:
  - limit=9, step=3, down, count=1 -> next=8, tc pulse.
  - limit=2, step=15, up, count=1 -> next=0.
- Saturate: limit=200, step=7, up, count=198 -> 200, tc=1, at_limit=1. A further step holds at 200 with tc=1 again. Down from 4 with step 7 -> 0, zero=1.
- Load error and flag priority: limit=10, data_load=50 -> count_out=10, load_err=1. Same cycle as a boundary event with clr_flags=1 -> wrap_flag stays 1.
- Hold cases:
  - ce=0 with step=5 -> count_out stable over 4 cycles.
  - step=0 with ce=1 -> no change, no tc.
  - WIDTH=16: limit=65535, count=65534, step=1, up -> 65535 with no event; the next step wraps to 0.

Source files
------------

// File: rtl/updown_mod_counter_if.sv
// Control/status bundle for updown_mod_counter.
// master: drives ce/load_n/up_down/data_load/limit/step/sat_en/clr_flags and observes status.
// slave:  the counter; drives count_out/zero/at_limit/tc/wrap_flag/load_err.
interface updown_mod_counter_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
);
  logic              ce;
  logic              load_n;
  logic              up_down;
  logic [WIDTH-1:0]  data_load;
  logic [WIDTH-1:0]  limit;
  logic [STEP_W-1:0] step;
  logic              sat_en;
  logic              clr_flags;
  logic [WIDTH-1:0]  count_out;
  logic              zero;
  logic              at_limit;
  logic              tc;
  logic              wrap_flag;
  logic              load_err;

  modport master (
    output ce, load_n, up_down, data_load, limit, step, sat_en, clr_flags,
    input  count_out, zero, at_limit, tc, wrap_flag, load_err
  );

  modport slave (
    input  ce, load_n, up_down, data_load, limit, step, sat_en, clr_flags,
    output count_out, zero, at_limit, tc, wrap_flag, load_err
  );
endinterface

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with runtime limit, programmable step, wrap/saturate,
// one-cycle terminal-count pulse and sticky wrap/load-error flags.
// Ports: clk, rst_n (async active-low), bus (updown_mod_counter_if.slave).
module updown_mod_counter #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  updown_mod_counter_if.slave   bus
);
  // One extra bit so count+step and limit+1 never truncate at 2^WIDTH.
  localparam int EW = WIDTH + 1;
  localparam logic [EW-1:0] ONE_E = EW'(1);

  logic [WIDTH-1:0] count_r;
  logic             tc_r;
  logic             wrap_flag_r;
  logic             load_err_r;

  logic [EW-1:0]    cnt_e;
  logic [EW-1:0]    lim_e;
  logic [EW-1:0]    s_e;
  logic [EW-1:0]    sum_e;
  logic [EW-1:0]    wrap_up_e;
  logic [EW-1:0]    under_e;
  logic [WIDTH-1:0] next_cnt;
  logic             evt;
  logic             ld_over;

  always_comb begin
    cnt_e     = {1'b0, count_r};
    lim_e     = {1'b0, bus.limit};
    s_e       = {{(EW-STEP_W){1'b0}}, bus.step};
    sum_e     = cnt_e + s_e;
    wrap_up_e = sum_e - lim_e - ONE_E;
    // Amount by which a down step passes below zero, minus one.
    under_e   = s_e - cnt_e - ONE_E;
    next_cnt  = count_r;
    evt       = 1'b0;
    ld_over   = (bus.data_load > bus.limit);

    // step=0 is a pure hold, even when count_r sits above a lowered limit.
    if (bus.ce && (bus.step != '0)) begin
      if (bus.up_down) begin
        if (sum_e <= lim_e) begin
          next_cnt = sum_e[WIDTH-1:0];
        end else begin
          evt = 1'b1;
          if (bus.sat_en)              next_cnt = bus.limit;
          else if (wrap_up_e > lim_e)  next_cnt = '0;
          else                         next_cnt = wrap_up_e[WIDTH-1:0];
        end
      end else begin
        if (s_e <= cnt_e) begin
          next_cnt = count_r - WIDTH'(bus.step);
        end else begin
          evt = 1'b1;
          if (bus.sat_en)              next_cnt = '0;
          else if (under_e > lim_e)    next_cnt = bus.limit;
          else                         next_cnt = bus.limit - under_e[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r     <= '0;
      tc_r        <= 1'b0;
      wrap_flag_r <= 1'b0;
      load_err_r  <= 1'b0;
    end else if (!bus.load_n) begin
      count_r     <= ld_over ? bus.limit : bus.data_load;
      tc_r        <= 1'b0;
      // Set beats clear on each flag independently.
      load_err_r  <= ld_over ? 1'b1 : (bus.clr_flags ? 1'b0 : load_err_r);
      wrap_flag_r <= bus.clr_flags ? 1'b0 : wrap_flag_r;
    end else begin
      count_r     <= next_cnt;
      tc_r        <= evt;
      wrap_flag_r <= evt ? 1'b1 : (bus.clr_flags ? 1'b0 : wrap_flag_r);
      load_err_r  <= bus.clr_flags ? 1'b0 : load_err_r;
    end
  end

  assign bus.count_out = count_r;
  assign bus.tc        = tc_r;
  assign bus.wrap_flag = wrap_flag_r;
  assign bus.load_err  = load_err_r;
  assign bus.zero      = (count_r == '0);
  assign bus.at_limit  = (count_r == bus.limit);
endmodule
